// File: rtl/xbar_axi_pkg.sv
// Shared AXI crossbar types: burst encodings, beat-generator FSM states and
// a helper that qualifies WRAP burst lengths.
package xbar_axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // WRAP is only defined for 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [31:0] len);
    return (len == 32'd1) || (len == 32'd3) || (len == 32'd7) || (len == 32'd15);
  endfunction

endpackage

// File: rtl/aw_beat_gen_if.sv
// Bus bundles around the AW beat generator: the show-ahead FIFO front and
// the per-beat address stream toward the W datapath.
interface aw_fifo_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int SIZE_WIDTH = 3
);
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [ID_WIDTH-1:0]   front_AWID;
  logic [ADDR_WIDTH-1:0] front_AWADDR;
  logic [LEN_WIDTH-1:0]  front_AWLEN;
  logic [SIZE_WIDTH-1:0] front_AWSIZE;
  logic [1:0]            front_AWBURST;

  modport master (output fifo_empty, front_AWID, front_AWADDR, front_AWLEN,
                  front_AWSIZE, front_AWBURST, input fifo_pop);
  modport slave  (input fifo_empty, front_AWID, front_AWADDR, front_AWLEN,
                  front_AWSIZE, front_AWBURST, output fifo_pop);
endinterface

interface aw_beat_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int SIZE_WIDTH = 3
);
  logic                  beat_valid;
  logic                  beat_ready;
  logic [ID_WIDTH-1:0]   beat_id;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [SIZE_WIDTH-1:0] beat_size;
  logic [LEN_WIDTH-1:0]  beat_idx;
  logic                  beat_last;

  modport master (output beat_valid, beat_id, beat_addr, beat_size, beat_idx,
                  beat_last, input beat_ready);
  modport slave  (input beat_valid, beat_id, beat_addr, beat_size, beat_idx,
                  beat_last, output beat_ready);
endinterface

// File: rtl/axi_next_addr.sv
// Combinational AXI beat-address stepper (FIXED/INCR/WRAP); RSVD steps as INCR.
// Shared by the AW and AR beat generators.
module axi_next_addr
  import xbar_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int SIZE_WIDTH = 3
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [SIZE_WIDTH-1:0] size_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  burst_t                burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  logic [ADDR_WIDTH-1:0] beat_bytes;
  logic [ADDR_WIDTH-1:0] beat_mask;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  assign beat_bytes = ADDR_WIDTH'(1) << size_i;
  assign beat_mask  = beat_bytes - ADDR_WIDTH'(1);
  assign wrap_mask  = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);

  always_comb begin
    next_addr_o = addr_i;
    case (burst_i)
      FIXED:   next_addr_o = addr_i;
      WRAP:    next_addr_o = (addr_i & ~wrap_mask) | ((addr_i + beat_bytes) & wrap_mask);
      default: next_addr_o = (addr_i & ~beat_mask) + beat_bytes;
    endcase
  end

endmodule

// File: rtl/aw_beat_gen.sv
// AW beat generator: pops write-address commands from the FIFO front and
// emits one beat address per cycle, chaining bursts without bubbles.
module aw_beat_gen
  import xbar_axi_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int SIZE_WIDTH = 3
) (
  input  logic       clk,
  input  logic       nrst,
  aw_fifo_if.slave   fifo,
  aw_beat_if.master  beat,
  output logic       busy,
  output logic       burst_err
);

  state_t                state_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [SIZE_WIDTH-1:0] size_q;
  burst_t                burst_q;
  logic [LEN_WIDTH-1:0]  idx_q;
  logic                  valid_q;
  logic                  err_q;

  burst_t                burst_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  err_d;
  logic [ADDR_WIDTH-1:0] step_addr;
  logic [ADDR_WIDTH-1:0] front_mask;
  logic                  handshake;
  logic                  last;
  logic                  pop;

  assign front_mask = (ADDR_WIDTH'(1) << fifo.front_AWSIZE) - ADDR_WIDTH'(1);

  // Sanitise the front command: illegal bursts fall back to INCR, and an
  // unaligned WRAP start is pulled down to its beat boundary.
  always_comb begin
    burst_d = burst_t'(fifo.front_AWBURST);
    addr_d  = fifo.front_AWADDR;
    err_d   = 1'b0;
    if (burst_d == RSVD) begin
      burst_d = INCR;
      err_d   = 1'b1;
    end else if (burst_d == WRAP) begin
      if (!wrap_len_ok(32'(fifo.front_AWLEN))) begin
        burst_d = INCR;
        err_d   = 1'b1;
      end else if ((fifo.front_AWADDR & front_mask) != '0) begin
        addr_d = fifo.front_AWADDR & ~front_mask;
        err_d  = 1'b1;
      end
    end
  end

  assign handshake = valid_q & beat.beat_ready;
  assign last      = (idx_q == len_q);
  assign pop       = nrst & ~fifo.fifo_empty & ((state_q == IDLE) | (handshake & last));

  axi_next_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .SIZE_WIDTH (SIZE_WIDTH)
  ) u_next_addr (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (step_addr)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= FIXED;
      idx_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (pop) begin
        state_q <= BURST;
        id_q    <= fifo.front_AWID;
        addr_q  <= addr_d;
        len_q   <= fifo.front_AWLEN;
        size_q  <= fifo.front_AWSIZE;
        burst_q <= burst_d;
        idx_q   <= '0;
        valid_q <= 1'b1;
        err_q   <= err_d;
      end else if (handshake) begin
        if (last) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end else begin
          idx_q  <= idx_q + LEN_WIDTH'(1);
          addr_q <= step_addr;
        end
      end
    end
  end

  assign fifo.fifo_pop   = pop;
  assign beat.beat_valid = valid_q;
  assign beat.beat_id    = id_q;
  assign beat.beat_addr  = addr_q;
  assign beat.beat_size  = size_q;
  assign beat.beat_idx   = idx_q;
  assign beat.beat_last  = last;
  assign busy            = (state_q == BURST);
  assign burst_err       = err_q;

endmodule

// File: tb/tb_aw_beat_gen.sv
// Directed bench for aw_beat_gen: a small array-backed FIFO model feeds
// commands; beats are compared against hand-computed addresses.
module tb_aw_beat_gen;

  logic clk;
  logic nrst;
  logic busy;
  logic burst_err;

  aw_fifo_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .LEN_WIDTH(4), .SIZE_WIDTH(3)) f ();
  aw_beat_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .LEN_WIDTH(4), .SIZE_WIDTH(3)) b ();

  aw_beat_gen #(.ID_WIDTH(4), .ADDR_WIDTH(32), .LEN_WIDTH(4), .SIZE_WIDTH(3)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .fifo      (f.slave),
    .beat      (b.master),
    .busy      (busy),
    .burst_err (burst_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  m_id    [16];
  logic [31:0] m_addr  [16];
  logic [3:0]  m_len   [16];
  logic [2:0]  m_size  [16];
  logic [1:0]  m_burst [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_cnt = 0;
  int pop_empty_cnt = 0;

  assign f.fifo_empty    = (wr_ptr == rd_ptr);
  assign f.front_AWID    = m_id[rd_ptr[3:0]];
  assign f.front_AWADDR  = m_addr[rd_ptr[3:0]];
  assign f.front_AWLEN   = m_len[rd_ptr[3:0]];
  assign f.front_AWSIZE  = m_size[rd_ptr[3:0]];
  assign f.front_AWBURST = m_burst[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (f.fifo_pop) begin
      if (wr_ptr == rd_ptr) pop_empty_cnt <= pop_empty_cnt + 1;
      else rd_ptr <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_err = 0;
  logic [31:0] exp_addr [16];
  int p0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
    m_id[wr_ptr[3:0]]    = id;
    m_addr[wr_ptr[3:0]]  = addr;
    m_len[wr_ptr[3:0]]   = len;
    m_size[wr_ptr[3:0]]  = size;
    m_burst[wr_ptr[3:0]] = burst;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic set_exp(input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] a3);
    exp_addr[0] = a0;
    exp_addr[1] = a1;
    exp_addr[2] = a2;
    exp_addr[3] = a3;
  endtask

  task automatic check_beat(input string tag, input logic [31:0] addr, input int idx,
                            input logic last, input logic [3:0] id);
    check_val({tag, "_valid"}, 64'(b.beat_valid), 64'd1);
    check_val({tag, "_addr"},  64'(b.beat_addr),  64'(addr));
    check_val({tag, "_idx"},   64'(b.beat_idx),   64'(idx));
    check_val({tag, "_last"},  64'(b.beat_last),  64'(last));
    check_val({tag, "_id"},    64'(b.beat_id),    64'(id));
  endtask

  // Single command into an empty FIFO, full-rate consumer.
  task automatic run_cmd(input string tag, input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic exp_err);
    @(negedge clk);
    push(id, addr, len, size, burst);
    #1;
    check_val({tag, "_pop_load"}, 64'(f.fifo_pop), 64'd1);
    p0 = pop_cnt;
    for (int k = 0; k <= int'(len); k++) begin
      @(negedge clk);
      check_beat(tag, exp_addr[k], k, (k == int'(len)), id);
      check_val({tag, "_size"}, 64'(b.beat_size), 64'(size));
      check_val({tag, "_err"}, 64'(burst_err), (k == 0) ? 64'(exp_err) : 64'd0);
      check_val({tag, "_pop_mid"}, 64'(f.fifo_pop), 64'd0);
    end
    @(negedge clk);
    check_val({tag, "_idle_valid"}, 64'(b.beat_valid), 64'd0);
    check_val({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_pops"}, 64'(pop_cnt - p0), 64'd1);
    $display("burst %s id=%0h addr=%0h len=%0d size=%0d burst=%0d", tag, id, addr, len, size, burst);
  endtask

  initial begin
    nrst = 1'b0;
    b.beat_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_valid", 64'(b.beat_valid), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_err", 64'(burst_err), 64'd0);
    check_val("rst_addr", 64'(b.beat_addr), 64'd0);
    check_val("rst_idx", 64'(b.beat_idx), 64'd0);
    check_val("rst_pop", 64'(f.fifo_pop), 64'd0);
    nrst = 1'b1;

    set_exp(32'h1000, 32'h1004, 32'h1008, 32'h100C);
    run_cmd("incr", 4'h1, 32'h1000, 4'd3, 3'd2, 2'b01, 1'b0);
    set_exp(32'h1008, 32'h100C, 32'h1000, 32'h1004);
    run_cmd("wrap", 4'h2, 32'h1008, 4'd3, 3'd2, 2'b10, 1'b0);
    set_exp(32'h2000, 32'h2000, 32'h2000, 32'h0);
    run_cmd("fixed", 4'h3, 32'h2000, 4'd2, 3'd3, 2'b00, 1'b0);
    set_exp(32'h1003, 32'h1004, 32'h1008, 32'h0);
    run_cmd("incr_unal", 4'h4, 32'h1003, 4'd2, 3'd2, 2'b01, 1'b0);
    set_exp(32'h0040, 32'h0, 32'h0, 32'h0);
    run_cmd("single", 4'h5, 32'h0040, 4'd0, 3'd1, 2'b01, 1'b0);
    set_exp(32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0);
    run_cmd("ovf", 4'h6, 32'hFFFF_FFFC, 4'd1, 3'd2, 2'b01, 1'b0);
    set_exp(32'h1008, 32'h100C, 32'h1010, 32'h0);
    run_cmd("wrap_len2", 4'h7, 32'h1008, 4'd2, 3'd2, 2'b10, 1'b1);
    set_exp(32'h3000, 32'h3001, 32'h0, 32'h0);
    run_cmd("rsvd", 4'h8, 32'h3000, 4'd1, 3'd0, 2'b11, 1'b1);
    set_exp(32'h1008, 32'h100C, 32'h1000, 32'h1004);
    run_cmd("wrap_unal", 4'h9, 32'h100A, 4'd3, 3'd2, 2'b10, 1'b1);

    // Back-to-back: two queued INCR len-1 bursts, no bubble
    @(negedge clk);
    push(4'hA, 32'h0100, 4'd1, 3'd2, 2'b01);
    push(4'hB, 32'h0200, 4'd1, 3'd2, 2'b01);
    #1;
    check_val("b2b_pop_load", 64'(f.fifo_pop), 64'd1);
    p0 = pop_cnt;
    @(negedge clk);
    check_beat("b2b_a0", 32'h0100, 0, 1'b0, 4'hA);
    check_val("b2b_a0_pop", 64'(f.fifo_pop), 64'd0);
    @(negedge clk);
    check_beat("b2b_a1", 32'h0104, 1, 1'b1, 4'hA);
    check_val("b2b_a1_pop", 64'(f.fifo_pop), 64'd1);
    @(negedge clk);
    check_beat("b2b_b0", 32'h0200, 0, 1'b0, 4'hB);
    check_val("b2b_b0_pop", 64'(f.fifo_pop), 64'd0);
    check_val("b2b_b0_err", 64'(burst_err), 64'd0);
    @(negedge clk);
    check_beat("b2b_b1", 32'h0204, 1, 1'b1, 4'hB);
    check_val("b2b_b1_pop", 64'(f.fifo_pop), 64'd0);
    @(negedge clk);
    check_val("b2b_idle", 64'(b.beat_valid), 64'd0);
    check_val("b2b_pops", 64'(pop_cnt - p0), 64'd2);
    $display("burst b2b ids=a,b beats=4");

    // Backpressure on beat 1
    @(negedge clk);
    push(4'hC, 32'h0500, 4'd3, 3'd2, 2'b01);
    @(negedge clk);
    check_beat("bp0", 32'h0500, 0, 1'b0, 4'hC);
    @(negedge clk);
    b.beat_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check_beat("bp_hold", 32'h0504, 1, 1'b0, 4'hC);
      check_val("bp_hold_pop", 64'(f.fifo_pop), 64'd0);
    end
    b.beat_ready = 1'b1;
    @(negedge clk);
    check_beat("bp2", 32'h0508, 2, 1'b0, 4'hC);
    @(negedge clk);
    check_beat("bp3", 32'h050C, 3, 1'b1, 4'hC);
    @(negedge clk);
    check_val("bp_idle", 64'(b.beat_valid), 64'd0);
    $display("burst bp id=c beats=4 stall=5");

    // Reset mid-burst at idx 2 with one command still queued
    @(negedge clk);
    push(4'hD, 32'h0600, 4'd3, 3'd2, 2'b01);
    push(4'hE, 32'h0700, 4'd0, 3'd2, 2'b01);
    @(negedge clk);
    check_beat("rm0", 32'h0600, 0, 1'b0, 4'hD);
    @(negedge clk);
    @(negedge clk);
    check_beat("rm2", 32'h0608, 2, 1'b0, 4'hD);
    nrst = 1'b0;
    #1;
    check_val("rm_pop_in_rst", 64'(f.fifo_pop), 64'd0);
    check_val("rm_depth0", 64'(wr_ptr - rd_ptr), 64'd1);
    @(negedge clk);
    check_val("rm_valid", 64'(b.beat_valid), 64'd0);
    check_val("rm_busy", 64'(busy), 64'd0);
    check_val("rm_addr", 64'(b.beat_addr), 64'd0);
    check_val("rm_idx", 64'(b.beat_idx), 64'd0);
    @(negedge clk);
    check_val("rm_depth1", 64'(wr_ptr - rd_ptr), 64'd1);
    nrst = 1'b1;
    #1;
    check_val("rm_pop_after", 64'(f.fifo_pop), 64'd1);
    @(negedge clk);
    check_beat("rm_next", 32'h0700, 0, 1'b1, 4'hE);
    @(negedge clk);
    check_val("rm_idle", 64'(b.beat_valid), 64'd0);
    check_val("rm_depth_end", 64'(wr_ptr - rd_ptr), 64'd0);
    check_val("pop_when_empty", 64'(pop_empty_cnt), 64'd0);
    $display("burst reset_mid id=d dropped, id=e beats=1");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
